// File: rtl/wdt_pkg.sv
// ============================================================================
// Module  : wdt_pkg
// Brief   : Shared types and default widths for the multi-channel watchdog.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wdt_pkg;

    typedef enum logic [1:0] {
        WDT_IDLE    = 2'd0,
        WDT_COUNT   = 2'd1,
        WDT_TIMEOUT = 2'd2
    } wdt_state_e;

    localparam int unsigned C_DEF_CNT_W   = 32;
    localparam int unsigned C_DEF_PRESC_W = 16;

endpackage

`default_nettype wire

// File: rtl/wdt_channel.sv
// ============================================================================
// Module  : wdt_channel
// Brief   : One watchdog channel: state machine plus tick counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wdt_channel
    import wdt_pkg::*;
#(
    parameter int unsigned CNT_W = C_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
    input  logic             kick,
    input  logic             win_en,
    input  logic             clr,
    input  logic [CNT_W-1:0] toc,
    input  logic [CNT_W-1:0] win_lo,
    output logic             wto,
    output logic             wto_early
);

    wdt_state_e       r_state;
    wdt_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_early;
    logic             w_early_nxt;
    logic [CNT_W:0]   w_cnt_inc;

    // One bit wider so an all-ones timeout never wraps back to zero.
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WDT_IDLE;
            r_cnt   <= '0;
            r_early <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_early <= w_early_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_early_nxt = r_early;
        case (r_state)
            WDT_IDLE: begin
                w_cnt_nxt   = '0;
                w_early_nxt = 1'b0;
                if (en) w_state_nxt = WDT_COUNT;
            end
            WDT_COUNT: begin
                if (!en) begin
                    w_state_nxt = WDT_IDLE;
                    w_cnt_nxt   = '0;
                end else if (kick) begin
                    if (win_en && (r_cnt < win_lo)) begin
                        w_state_nxt = WDT_TIMEOUT;
                        w_early_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end else if (tick) begin
                    if (w_cnt_inc >= {1'b0, toc}) begin
                        w_state_nxt = WDT_TIMEOUT;
                        w_early_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
                    end
                end
            end
            WDT_TIMEOUT: begin
                if (!en) begin
                    w_state_nxt = WDT_IDLE;
                    w_cnt_nxt   = '0;
                    w_early_nxt = 1'b0;
                end else if (clr) begin
                    w_state_nxt = WDT_COUNT;
                    w_cnt_nxt   = '0;
                    w_early_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = WDT_IDLE;
                w_cnt_nxt   = '0;
                w_early_nxt = 1'b0;
            end
        endcase
    end

    assign wto       = (r_state == WDT_TIMEOUT);
    assign wto_early = r_early;

endmodule

`default_nettype wire

// File: rtl/wdt_multi.sv
// ============================================================================
// Module  : wdt_multi
// Brief   : Multi-channel watchdog with shared prescaler and combined timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wdt_multi
    import wdt_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = C_DEF_CNT_W,
    parameter int unsigned PRESC_W = C_DEF_PRESC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PRESC_W-1:0]      presc_div,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       ch_kick,
    input  logic [NUM_CH-1:0]       ch_win_en,
    input  logic [NUM_CH*CNT_W-1:0] ch_toc,
    input  logic [NUM_CH*CNT_W-1:0] ch_win_lo,
    input  logic [NUM_CH-1:0]       ch_clr,
    output logic [NUM_CH-1:0]       wto,
    output logic [NUM_CH-1:0]       wto_early,
    output logic                    wto_any
);

    logic [PRESC_W-1:0] r_presc;
    logic               w_any_en;
    logic               w_tick;
    logic               r_wto_any;

    assign w_any_en = |ch_en;
    // Greater-or-equal so lowering presc_div below the running count wraps at once.
    assign w_tick   = w_any_en && (r_presc >= presc_div);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= '0;
            r_wto_any <= 1'b0;
        end else begin
            if (!w_any_en || w_tick) r_presc <= '0;
            else                     r_presc <= r_presc + {{(PRESC_W-1){1'b0}}, 1'b1};
            r_wto_any <= |wto;
        end
    end

    assign wto_any = r_wto_any;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        wdt_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (w_tick),
            .en        (ch_en[i]),
            .kick      (ch_kick[i]),
            .win_en    (ch_win_en[i]),
            .clr       (ch_clr[i]),
            .toc       (ch_toc[i*CNT_W +: CNT_W]),
            .win_lo    (ch_win_lo[i*CNT_W +: CNT_W]),
            .wto       (wto[i]),
            .wto_early (wto_early[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_wdt_multi.sv
// ============================================================================
// Module  : tb_wdt_multi
// Brief   : Directed, table-driven self-checking bench for wdt_multi.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wdt_multi;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 32;
    localparam int PRESC_W = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [PRESC_W-1:0]      presc_div;
    logic [NUM_CH-1:0]       ch_en, ch_kick, ch_win_en, ch_clr;
    logic [NUM_CH*CNT_W-1:0] ch_toc, ch_win_lo;
    logic [NUM_CH-1:0]       wto, wto_early;
    logic                    wto_any;

    int n_cmp = 0;
    int n_bad = 0;

    wdt_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .rst(rst), .presc_div(presc_div), .ch_en(ch_en),
        .ch_kick(ch_kick), .ch_win_en(ch_win_en), .ch_toc(ch_toc),
        .ch_win_lo(ch_win_lo), .ch_clr(ch_clr), .wto(wto),
        .wto_early(wto_early), .wto_any(wto_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en, kick, clr, win_en;
        logic [31:0] toc, win_lo;
        logic        exp_wto, exp_early, exp_any;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ch_en = '0; ch_kick = '0; ch_clr = '0; ch_win_en = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0]  = '{1,0,0,0, 5,0, 0,0,0};
        vecs[1]  = '{1,0,0,0, 5,0, 0,0,0};
        vecs[2]  = '{1,0,0,0, 5,0, 0,0,0};
        vecs[3]  = '{1,0,0,0, 5,0, 0,0,0};
        vecs[4]  = '{1,0,0,0, 5,0, 0,0,0};
        vecs[5]  = '{1,0,0,0, 5,0, 1,0,0};
        vecs[6]  = '{1,0,0,0, 5,0, 1,0,1};
        vecs[7]  = '{1,1,0,0, 5,0, 1,0,1};
        vecs[8]  = '{1,0,1,0, 5,0, 0,0,1};
        vecs[9]  = '{1,0,0,0, 5,0, 0,0,0};
        vecs[10] = '{0,0,0,0, 5,0, 0,0,0};
        vecs[11] = '{1,0,0,1, 8,3, 0,0,0};
        vecs[12] = '{1,0,0,1, 8,3, 0,0,0};
        vecs[13] = '{1,1,0,1, 8,3, 1,1,0};
        vecs[14] = '{1,0,1,1, 8,3, 0,0,1};
        vecs[15] = '{1,0,0,1, 8,3, 0,0,0};
        vecs[16] = '{1,0,0,1, 8,3, 0,0,0};
        vecs[17] = '{1,0,0,1, 8,3, 0,0,0};
        vecs[18] = '{1,1,0,1, 8,3, 0,0,0};
        vecs[19] = '{1,1,0,1, 3,5, 1,1,0};
        vecs[20] = '{0,0,0,0, 3,5, 0,0,1};
        vecs[21] = '{0,0,0,0, 3,5, 0,0,0};

        rst = 1'b1; presc_div = '0; ch_toc = '0; ch_win_lo = '0;
        ch_en = '0; ch_kick = '0; ch_clr = '0; ch_win_en = '0;
        step(); step();
        rst = 1'b0;
        check("reset_wto", {28'd0, wto}, 32'd0);
        check("reset_early", {28'd0, wto_early}, 32'd0);
        check("reset_any", {31'd0, wto_any}, 32'd0);

        // Table: channel 0 only, tick every cycle.
        for (int k = 0; k < 22; k++) begin
            ch_en[0] = vecs[k].en; ch_kick[0] = vecs[k].kick;
            ch_clr[0] = vecs[k].clr; ch_win_en[0] = vecs[k].win_en;
            ch_toc[31:0] = vecs[k].toc; ch_win_lo[31:0] = vecs[k].win_lo;
            step();
            ch_kick = '0; ch_clr = '0;
            check($sformatf("vec%0d_wto", k), {31'd0, wto[0]}, {31'd0, vecs[k].exp_wto});
            check($sformatf("vec%0d_early", k), {31'd0, wto_early[0]}, {31'd0, vecs[k].exp_early});
            check($sformatf("vec%0d_any", k), {31'd0, wto_any}, {31'd0, vecs[k].exp_any});
        end

        // Periodic kicks keep the channel alive; a kick on the terminal tick wins.
        do_reset();
        ch_win_en = '0; ch_toc[31:0] = 32'd5; ch_en[0] = 1'b1;
        step();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            ch_kick[0] = (i % 3 == 2);
            step();
            if (wto[0]) n++;
        end
        ch_kick = '0;
        check("kick_periodic_no_wto", n, 0);
        repeat (3) step();
        ch_kick[0] = 1'b1;
        step();
        ch_kick = '0;
        check("kick_terminal_no_wto", {31'd0, wto[0]}, 32'd0);
        repeat (4) step();
        check("after_kick_cnt4", {31'd0, wto[0]}, 32'd0);
        step();
        check("after_kick_timeout", {31'd0, wto[0]}, 32'd1);

        // Prescaler divide-by-4, two channels enabled, only ch0 times out.
        do_reset();
        presc_div = 16'd3;
        ch_toc[31:0] = 32'd2; ch_toc[63:32] = 32'd1000;
        ch_en = 4'b0011;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (wto[0]) break;
        end
        check("presc_timeout_edges", n, 8);
        check("presc_only_ch0", {28'd0, wto}, 32'h1);

        // toc=0 times out on first tick; all-ones never expires; live toc change.
        do_reset();
        presc_div = '0;
        ch_toc[31:0] = 32'd0; ch_toc[95:64] = 32'hFFFF_FFFF;
        ch_en = 4'b0001;
        step();
        check("toc0_count", {31'd0, wto[0]}, 32'd0);
        step();
        check("toc0_timeout", {31'd0, wto[0]}, 32'd1);
        ch_en = 4'b0101;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (wto[2]) n++;
        end
        check("tocmax_no_wto", n, 0);
        ch_toc[95:64] = 32'd10;
        step();
        check("toc_live_lower", {28'd0, wto}, 32'h5);

        // Reset mid-operation, then disable from TIMEOUT.
        do_reset();
        ch_toc[31:0] = 32'd1; ch_toc[63:32] = 32'd1000;
        ch_en = 4'b0011;
        repeat (3) step();
        check("pre_rst_wto", {28'd0, wto}, 32'h1);
        check("pre_rst_any", {31'd0, wto_any}, 32'd1);
        rst = 1'b1;
        step();
        check("rst_wto", {28'd0, wto}, 32'd0);
        check("rst_early", {28'd0, wto_early}, 32'd0);
        check("rst_any", {31'd0, wto_any}, 32'd0);
        rst = 1'b0;
        repeat (2) step();
        check("post_rst_timeout", {28'd0, wto}, 32'h1);
        ch_en = 4'b0010;
        step();
        check("dis_timeout_idle", {28'd0, wto}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
